// File: rtl/lstm_bp_ctrl_if.sv
// Control bus between the LSTM training sequencer (master) and the host/array side (slave).
// The cost-logging signals exist only when LSTM_BP_CTRL_COST_LOG_EN is defined.
interface lstm_bp_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_abort;
  logic             o_busy;
  logic             o_done;
  logic             o_sel;
  logic             o_load_in;
  logic             o_load_h;
  logic             o_load_bp;
  logic             o_load_t;
  logic             o_wr;
  logic [WIDTH-1:0] o_addr_t;
  logic [15:0]      o_epoch;
  logic [7:0]       o_step;
`ifdef LSTM_BP_CTRL_COST_LOG_EN
  logic [WIDTH-1:0] i_cost;
  logic [WIDTH-1:0] o_cost_last;
  logic [WIDTH-1:0] o_cost_min;
  logic             o_cost_valid;

  modport master (
    input  i_start, i_abort, i_cost,
    output o_busy, o_done, o_sel, o_load_in, o_load_h, o_load_bp, o_load_t, o_wr,
           o_addr_t, o_epoch, o_step, o_cost_last, o_cost_min, o_cost_valid
  );
  modport slave (
    output i_start, i_abort, i_cost,
    input  o_busy, o_done, o_sel, o_load_in, o_load_h, o_load_bp, o_load_t, o_wr,
           o_addr_t, o_epoch, o_step, o_cost_last, o_cost_min, o_cost_valid
  );
`else
  modport master (
    input  i_start, i_abort,
    output o_busy, o_done, o_sel, o_load_in, o_load_h, o_load_bp, o_load_t, o_wr,
           o_addr_t, o_epoch, o_step
  );
  modport slave (
    output i_start, i_abort,
    input  o_busy, o_done, o_sel, o_load_in, o_load_h, o_load_bp, o_load_t, o_wr,
           o_addr_t, o_epoch, o_step
  );
`endif
endinterface

// File: rtl/lstm_bp_ctrl.sv
// Training sequencer for the LSTM array with backprop: label load, per-timestep forward pass, BP settle, weight write.
// Optional cost logging is enabled by defining LSTM_BP_CTRL_COST_LOG_EN.
module lstm_bp_ctrl #(
  parameter int WIDTH          = 32,
  parameter int NUM            = 45,
  parameter int NUM_LSTM       = 8,
  parameter int NUM_ITERATIONS = 8,
  parameter int LSTM_LAT       = 4,
  parameter int BP_LAT         = 4,
  parameter int EPOCHS         = 16,
  parameter int NUM_SAMPLES    = 2
) (
  input  logic          clk,
  input  logic          rst,
  lstm_bp_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LABEL, S_FILL, S_LDIN, S_COMP, S_LATCH, S_BPWAIT, S_WRITE, S_DONE
  } state_t;

  localparam logic [15:0] LABEL_LAST  = 16'(NUM_LSTM - 1);
  localparam logic [15:0] FILL_LAST   = 16'(NUM - 1);
  localparam logic [15:0] COMP_LAST   = 16'(LSTM_LAT - 1);
  localparam logic [15:0] BPWAIT_LAST = 16'(BP_LAT - 1);
  localparam logic [7:0]  STEP_LAST   = 8'(NUM_ITERATIONS - 1);
  localparam logic [15:0] EPOCH_LAST  = 16'(EPOCHS - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(NUM_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       step_q, step_d;
  logic [15:0]      epoch_q, epoch_d;
  logic [15:0]      sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sel_q, sel_d;
  logic             load_in_q, load_in_d;
  logic             load_h_q, load_h_d;
  logic             load_bp_q, load_bp_d;
  logic             load_t_q, load_t_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             cnt_last;
  logic [15:0]      sample_next;

  always_comb begin
    cnt_last = 1'b0;
    case (state_q)
      S_LABEL:  cnt_last = (cnt_q == LABEL_LAST);
      S_FILL:   cnt_last = (cnt_q == FILL_LAST);
      S_COMP:   cnt_last = (cnt_q == COMP_LAST);
      S_BPWAIT: cnt_last = (cnt_q == BPWAIT_LAST);
      default:  cnt_last = 1'b0;
    endcase
  end

  assign sample_next = (sample_q == SAMPLE_LAST) ? 16'd0 : sample_q + 16'd1;

  // Outputs are decoded from the next state so every strobe is a flop and lines up with its state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    epoch_d  = epoch_q;
    sample_d = sample_q;

    if (state_q != S_IDLE && bus.i_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      step_d  = '0;
      epoch_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          step_d  = '0;
          epoch_d = '0;
          if (bus.i_start) state_d = S_LABEL;
        end
        S_LABEL, S_FILL, S_COMP, S_BPWAIT: begin
          if (cnt_last) begin
            cnt_d = '0;
            case (state_q)
              S_LABEL: state_d = S_FILL;
              S_FILL:  state_d = S_LDIN;
              S_COMP:  state_d = S_LATCH;
              default: state_d = S_WRITE;
            endcase
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_LDIN: state_d = S_COMP;
        S_LATCH: begin
          if (step_q == STEP_LAST) begin
            state_d = S_BPWAIT;
          end else begin
            step_d  = step_q + 8'd1;
            state_d = S_FILL;
          end
        end
        S_WRITE: begin
          sample_d = sample_next;
          if (epoch_q == EPOCH_LAST) begin
            state_d = S_DONE;
          end else begin
            epoch_d = epoch_q + 16'd1;
            step_d  = '0;
            state_d = S_LABEL;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          step_d  = '0;
          epoch_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    load_t_d  = (state_d == S_LABEL);
    load_in_d = (state_d == S_LDIN);
    load_h_d  = (state_d == S_LATCH);
    load_bp_d = (state_d == S_LATCH);
    wr_d      = (state_d == S_WRITE);
    sel_d     = (state_d == S_BPWAIT) || (state_d == S_WRITE) ||
                ((step_d != 8'd0) && ((state_d == S_FILL) || (state_d == S_LDIN) ||
                                      (state_d == S_COMP) || (state_d == S_LATCH)));
    addr_d    = '0;
    if (state_d == S_LABEL)
      addr_d = WIDTH'(sample_d) * WIDTH'(NUM_LSTM) + WIDTH'(cnt_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      step_q    <= '0;
      epoch_q   <= '0;
      sample_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_q     <= 1'b0;
      load_in_q <= 1'b0;
      load_h_q  <= 1'b0;
      load_bp_q <= 1'b0;
      load_t_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      epoch_q   <= epoch_d;
      sample_q  <= sample_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sel_q     <= sel_d;
      load_in_q <= load_in_d;
      load_h_q  <= load_h_d;
      load_bp_q <= load_bp_d;
      load_t_q  <= load_t_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_sel     = sel_q;
  assign bus.o_load_in = load_in_q;
  assign bus.o_load_h  = load_h_q;
  assign bus.o_load_bp = load_bp_q;
  assign bus.o_load_t  = load_t_q;
  assign bus.o_wr      = wr_q;
  assign bus.o_addr_t  = addr_q;
  assign bus.o_epoch   = epoch_q;
  assign bus.o_step    = step_q;

`ifdef LSTM_BP_CTRL_COST_LOG_EN
  localparam logic [WIDTH-1:0] COST_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] cost_last_q, cost_last_d;
  logic [WIDTH-1:0] cost_min_q, cost_min_d;
  logic             cost_valid_q, cost_valid_d;

  // An aborted WRITE commits nothing, so it must not log a cost either.
  always_comb begin
    cost_last_d  = cost_last_q;
    cost_min_d   = cost_min_q;
    cost_valid_d = 1'b0;
    if (state_q == S_IDLE && bus.i_start)
      cost_min_d = COST_MAX;
    if (state_q == S_WRITE && !bus.i_abort) begin
      cost_last_d  = bus.i_cost;
      cost_valid_d = 1'b1;
      if ($signed(bus.i_cost) < $signed(cost_min_q))
        cost_min_d = bus.i_cost;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cost_last_q  <= '0;
      cost_min_q   <= '0;
      cost_valid_q <= 1'b0;
    end else begin
      cost_last_q  <= cost_last_d;
      cost_min_q   <= cost_min_d;
      cost_valid_q <= cost_valid_d;
    end
  end

  assign bus.o_cost_last  = cost_last_q;
  assign bus.o_cost_min   = cost_min_q;
  assign bus.o_cost_valid = cost_valid_q;
`endif

endmodule

// File: tb/tb_lstm_bp_ctrl.sv
// Self-checking bench for lstm_bp_ctrl: a timeline model derived from run position, compared every cycle,
// plus literal strobe-timeline checks. Cost-log checks are added when LSTM_BP_CTRL_COST_LOG_EN is defined.
module tb_lstm_bp_ctrl;

  localparam int WIDTH  = 32;
  localparam int NUM    = 4;
  localparam int NL     = 2;
  localparam int NI     = 2;
  localparam int LAT    = 3;
  localparam int BPL    = 2;
  localparam int EPOCHS = 2;
  localparam int NS     = 2;
  // Cycles per timestep (fill + load_in + compute + latch), per epoch, and the DONE cycle's run position.
  localparam int SL     = NUM + LAT + 2;
  localparam int EL     = NL + NI * SL + BPL + 1;
  localparam int TOTAL  = EPOCHS * EL + 1;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        sel;
    logic        loadIn;
    logic        loadH;
    logic        loadBp;
    logic        loadT;
    logic        wr;
    logic [31:0] addr;
    logic [15:0] epoch;
    logic [7:0]  step;
  } expT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rel = 0;
  bit   checkEn = 1'b0;

  // Model state: run position (0 = idle, 1 = first LABEL cycle, TOTAL = DONE) and sample bookkeeping.
  int   phase = 0;
  int   runSample = 0;
  int   mSample = 0;

  lstm_bp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  lstm_bp_ctrl #(
    .WIDTH(WIDTH), .NUM(NUM), .NUM_LSTM(NL), .NUM_ITERATIONS(NI),
    .LSTM_LAT(LAT), .BP_LAT(BPL), .EPOCHS(EPOCHS), .NUM_SAMPLES(NS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Expected outputs for a given run position, straight from the epoch/timestep arithmetic.
  function automatic expT expectOut(input int p, input int rs);
    expT e;
    int ep, t, u, v, st;
    e = '0;
    if (p == 0) return e;
    e.busy = 1'b1;
    if (p == TOTAL) begin
      e.done  = 1'b1;
      e.epoch = 16'(EPOCHS - 1);
      e.step  = 8'(NI - 1);
      return e;
    end
    ep = (p - 1) / EL;
    t  = (p - 1) % EL;
    e.epoch = 16'(ep);
    if (t < NL) begin
      e.loadT = 1'b1;
      e.addr  = 32'(((rs + ep) % NS) * NL + t);
    end else if (t - NL < NI * SL) begin
      u  = t - NL;
      st = u / SL;
      v  = u % SL;
      e.step   = 8'(st);
      e.loadIn = (v == NUM);
      e.loadH  = (v == SL - 1);
      e.loadBp = (v == SL - 1);
      e.sel    = (st != 0);
    end else begin
      e.step = 8'(NI - 1);
      e.sel  = 1'b1;
      e.wr   = ((t - NL - NI * SL) == BPL);
    end
    return e;
  endfunction

  function automatic bit isWrite(input int p);
    return (p >= 1) && (p < TOTAL) && (((p - 1) % EL) == EL - 1);
  endfunction

`ifdef LSTM_BP_CTRL_COST_LOG_EN
  localparam logic [31:0] COST_MAX = 32'h7fff_ffff;
  logic [31:0] mLast = '0;
  logic [31:0] mMin = '0;
  logic        mValid = 1'b0;
`endif

  // The model advances on the same edges as the DUT, using the inputs the DUT sees.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 0;
      runSample <= 0;
      mSample   <= 0;
`ifdef LSTM_BP_CTRL_COST_LOG_EN
      mLast  <= '0;
      mMin   <= '0;
      mValid <= 1'b0;
`endif
    end else begin
`ifdef LSTM_BP_CTRL_COST_LOG_EN
      mValid <= 1'b0;
`endif
      if (phase == 0) begin
        if (bus.i_start) begin
          phase     <= 1;
          runSample <= mSample;
`ifdef LSTM_BP_CTRL_COST_LOG_EN
          mMin <= COST_MAX;
`endif
        end
      end else if (bus.i_abort) begin
        phase   <= 0;
        mSample <= (runSample + (phase - 1) / EL) % NS;
      end else begin
`ifdef LSTM_BP_CTRL_COST_LOG_EN
        if (isWrite(phase)) begin
          mLast  <= bus.i_cost;
          mMin   <= ($signed(bus.i_cost) < $signed(mMin)) ? bus.i_cost : mMin;
          mValid <= 1'b1;
        end
`endif
        if (phase == TOTAL) begin
          phase   <= 0;
          mSample <= (runSample + EPOCHS) % NS;
        end else begin
          phase <= phase + 1;
        end
      end
    end
  end

  // Compare a DUT value against its required value and log a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Every negedge, once out of the initial reset, check all outputs against the model.
  always @(negedge clk) begin
    expT e;
    if (checkEn) begin
      e = expectOut(phase, runSample);
      checkOutput("busy",    {31'd0, bus.o_busy},    {31'd0, e.busy});
      checkOutput("done",    {31'd0, bus.o_done},    {31'd0, e.done});
      checkOutput("sel",     {31'd0, bus.o_sel},     {31'd0, e.sel});
      checkOutput("load_in", {31'd0, bus.o_load_in}, {31'd0, e.loadIn});
      checkOutput("load_h",  {31'd0, bus.o_load_h},  {31'd0, e.loadH});
      checkOutput("load_bp", {31'd0, bus.o_load_bp}, {31'd0, e.loadBp});
      checkOutput("load_t",  {31'd0, bus.o_load_t},  {31'd0, e.loadT});
      checkOutput("wr",      {31'd0, bus.o_wr},      {31'd0, e.wr});
      checkOutput("addr_t",  bus.o_addr_t,           e.addr);
      checkOutput("epoch",   {16'd0, bus.o_epoch},   {16'd0, e.epoch});
      checkOutput("step",    {24'd0, bus.o_step},    {24'd0, e.step});
`ifdef LSTM_BP_CTRL_COST_LOG_EN
      checkOutput("cost_last",  bus.o_cost_last,          mLast);
      checkOutput("cost_min",   bus.o_cost_min,           mMin);
      checkOutput("cost_valid", {31'd0, bus.o_cost_valid}, {31'd0, mValid});
`endif
    end
  end

  // Drive the host inputs; called at a negedge so they are stable for the next rising edge.
  task automatic applyStimulus(input logic start, input logic abort);
    bus.i_start = start;
    bus.i_abort = abort;
  endtask

  task automatic tick();
    @(negedge clk);
    rel++;
  endtask

  task automatic waitCycle(input int n);
    while (rel < n) tick();
  endtask

  // Pulse start during cycle 0; returns at the negedge of cycle 1.
  task automatic beginRun();
    applyStimulus(1'b1, 1'b0);
    rel = 0;
    tick();
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
`ifdef LSTM_BP_CTRL_COST_LOG_EN
    bus.i_cost = '0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",  {31'd0, bus.o_busy},   32'd0);
    checkOutput("reset_addr",  bus.o_addr_t,          32'd0);
    checkOutput("reset_epoch", {16'd0, bus.o_epoch},  32'd0);
    checkOutput("reset_wr",    {31'd0, bus.o_wr},     32'd0);
    rst = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);

    // Run 1: full strobe timeline.
`ifdef LSTM_BP_CTRL_COST_LOG_EN
    bus.i_cost = 32'h0040_0000;
`endif
    beginRun();
    checkOutput("r1_c1_load_t", {31'd0, bus.o_load_t}, 32'd1);
    checkOutput("r1_c1_addr",   bus.o_addr_t,          32'd0);
    waitCycle(2);  checkOutput("r1_c2_addr",    bus.o_addr_t,           32'd1);
    waitCycle(7);  checkOutput("r1_c7_load_in", {31'd0, bus.o_load_in}, 32'd1);
    waitCycle(11); checkOutput("r1_c11_load_h", {31'd0, bus.o_load_h},  32'd1);
                   checkOutput("r1_c11_sel",    {31'd0, bus.o_sel},     32'd0);
    waitCycle(12); checkOutput("r1_c12_sel",    {31'd0, bus.o_sel},     32'd1);
                   checkOutput("r1_c12_step",   {24'd0, bus.o_step},    32'd1);
    waitCycle(16); checkOutput("r1_c16_load_in",{31'd0, bus.o_load_in}, 32'd1);
    waitCycle(20); checkOutput("r1_c20_load_bp",{31'd0, bus.o_load_bp}, 32'd1);
    waitCycle(23); checkOutput("r1_c23_wr",     {31'd0, bus.o_wr},      32'd1);
    waitCycle(24); checkOutput("r1_c24_addr",   bus.o_addr_t,           32'd2);
                   checkOutput("r1_c24_epoch",  {16'd0, bus.o_epoch},   32'd1);
`ifdef LSTM_BP_CTRL_COST_LOG_EN
    checkOutput("r1_c24_cost_valid", {31'd0, bus.o_cost_valid}, 32'd1);
    checkOutput("r1_c24_cost_last",  bus.o_cost_last,           32'h0040_0000);
    bus.i_cost = 32'h0020_0000;
`endif
    waitCycle(25); checkOutput("r1_c25_addr",   bus.o_addr_t,           32'd3);
    waitCycle(46); checkOutput("r1_c46_wr",     {31'd0, bus.o_wr},      32'd1);
    waitCycle(47); checkOutput("r1_c47_done",   {31'd0, bus.o_done},    32'd1);
`ifdef LSTM_BP_CTRL_COST_LOG_EN
    checkOutput("r1_c47_cost_valid", {31'd0, bus.o_cost_valid}, 32'd1);
    checkOutput("r1_c47_cost_last",  bus.o_cost_last,           32'h0020_0000);
    checkOutput("r1_c47_cost_min",   bus.o_cost_min,            32'h0020_0000);
`endif
    waitCycle(48); checkOutput("r1_c48_busy",   {31'd0, bus.o_busy},    32'd0);
                   checkOutput("r1_c48_epoch",  {16'd0, bus.o_epoch},   32'd0);
    waitCycle(52);

    // Run 2: sample index has wrapped back to 0.
    beginRun();
    checkOutput("r2_c1_addr", bus.o_addr_t, 32'd0);
    waitCycle(24); checkOutput("r2_c24_addr", bus.o_addr_t,        32'd2);
    waitCycle(48); checkOutput("r2_c48_busy", {31'd0, bus.o_busy}, 32'd0);
    waitCycle(50);

    // Abort sampled at the end of cycle 15: idle in cycle 16, no write ever follows.
    beginRun();
    waitCycle(15); applyStimulus(1'b0, 1'b1);
    waitCycle(16); checkOutput("ab_c16_busy",    {31'd0, bus.o_busy},    32'd0);
                   checkOutput("ab_c16_load_in", {31'd0, bus.o_load_in}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    waitCycle(60); checkOutput("ab_c60_busy",    {31'd0, bus.o_busy},    32'd0);
    beginRun();
    checkOutput("ab_r_c1_addr", bus.o_addr_t, 32'd0);
    waitCycle(23); checkOutput("ab_r_c23_wr", {31'd0, bus.o_wr}, 32'd1);
    waitCycle(50);

    // Async reset during a COMP cycle of epoch 1, step 1: outputs clear before the next edge.
    beginRun();
    waitCycle(40);
    checkOutput("rs_pre_epoch", {16'd0, bus.o_epoch}, 32'd1);
    checkOutput("rs_pre_sel",   {31'd0, bus.o_sel},   32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rs_busy",  {31'd0, bus.o_busy},  32'd0);
    checkOutput("rs_sel",   {31'd0, bus.o_sel},   32'd0);
    checkOutput("rs_epoch", {16'd0, bus.o_epoch}, 32'd0);
    checkOutput("rs_step",  {24'd0, bus.o_step},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    beginRun();
    checkOutput("rs_r_c1_addr", bus.o_addr_t, 32'd0);
    waitCycle(50);

    // Start held high: one run, no restart while busy, immediate restart after DONE.
    applyStimulus(1'b1, 1'b0);
    rel = 0;
    waitCycle(24); checkOutput("hs_c24_addr",   bus.o_addr_t,          32'd2);
    waitCycle(47); checkOutput("hs_c47_done",   {31'd0, bus.o_done},   32'd1);
    waitCycle(48); checkOutput("hs_c48_busy",   {31'd0, bus.o_busy},   32'd0);
    waitCycle(49); checkOutput("hs_c49_load_t", {31'd0, bus.o_load_t}, 32'd1);
                   checkOutput("hs_c49_addr",   bus.o_addr_t,          32'd0);
    applyStimulus(1'b0, 1'b1);
    waitCycle(51);
    applyStimulus(1'b0, 1'b0);
    checkOutput("hs_end_busy", {31'd0, bus.o_busy}, 32'd0);
    waitCycle(55);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lstm_bp_ctrl.md
Name: lstm_bp_ctrl

Overview:
- Training sequencer that drives the control interface of the LSTM array-with-backprop block (sel, load_in, load_bp, load_t, load_h, wr, i_addr_t).
- Per epoch: loads the label vector, steps the forward pass through NUM_ITERATIONS timesteps while capturing each timestep's state into the BP shift registers, waits for backprop to settle, then commits the weight/bias update with a one-cycle wr.
- Sits beside the array in the top level; the host only issues start/abort.

Parameters:
- WIDTH, 32, width of o_addr_t.
- NUM, 45, input-vector length; cycles needed to fill the input shift register.
- NUM_LSTM, 8, label count per sample; number of load_t cycles.
- NUM_ITERATIONS, 8, timesteps per sample.
- LSTM_LAT, 4, cycles from load_in to valid h/c/gate outputs (must be ≥1).
- BP_LAT, 4, cycles from last load_bp to stable delta/new-weight values (must be ≥1).
- EPOCHS, 16, weight updates per start.
- NUM_SAMPLES, 2, label sets in label memory; sample index wraps modulo this.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  begin a run; sampled only in IDLE
- i_abort  in  1  synchronous abort; return to IDLE without wr
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the final WRITE
- o_sel  out  1  0 = zero recurrent state (timestep 0), 1 = use latched h
- o_load_in  out  1  latch the filled input vector
- o_load_h  out  1  latch h/c for the next timestep
- o_load_bp  out  1  push the current timestep into the BP history registers
- o_load_t  out  1  shift label data into the label register
- o_wr  out  1  commit new weights/biases
- o_addr_t  out  WIDTH  label-memory address
- o_epoch  out  16  current epoch index
- o_step  out  8  current timestep index

Behaviour:
- Clock is clk; reset rst is asynchronous, active-high.
- Reset: state IDLE; all outputs 0; epoch, step, sample and sub-counters 0.
- States and transitions:
  - IDLE: i_start=1 → LABEL on the next edge. First LABEL cycle is the cycle after start is sampled.
  - LABEL: NUM_LSTM cycles. o_load_t=1, o_addr_t = sample*NUM_LSTM + k for k = 0..NUM_LSTM-1. → FILL.
  - FILL: NUM cycles. All strobes 0. → LDIN.
  - LDIN: 1 cycle, o_load_in=1. → COMP.
  - COMP: LSTM_LAT cycles. → LATCH.
  - LATCH: 1 cycle, o_load_h=1 and o_load_bp=1 together. If step = NUM_ITERATIONS-1 → BPWAIT; otherwise step+1 → FILL.
  - BPWAIT: BP_LAT cycles. → WRITE.
  - WRITE: 1 cycle, o_wr=1. If epoch < EPOCHS-1: epoch+1, step=0, sample = (sample+1) mod NUM_SAMPLES, → LABEL. Otherwise → DONE.
  - DONE: 1 cycle, o_done=1. → IDLE. Epoch and step clear in IDLE; sample index persists across runs until reset.
- o_sel: 0 whenever step = 0 (FILL through LATCH); 1 for steps ≥1, BPWAIT and WRITE.
- o_addr_t: 0 outside LABEL.
- All outputs are registered, with no combinational path from inputs.
- Cycles per epoch = NUM_LSTM + NUM_ITERATIONS*(NUM + LSTM_LAT + 2) + BP_LAT + 1.
- Boundary and corner cases:
  - i_start while busy: ignored.
  - i_abort: highest priority in any non-IDLE state. Next state is IDLE, all strobes 0 that cycle, no o_wr and no o_done. i_abort in IDLE is a no-op.
  - i_start and i_abort both high in IDLE: start wins, because abort has no effect in IDLE.
  - rst mid-run: immediate IDLE, outputs 0, sample index cleared.
  - Counters compare with terminal values. No overflow for parameter values within the counter widths.

Optional Feature:
- Macro: LSTM_BP_CTRL_COST_LOG_EN.
- When defined, adds:
  - Input i_cost [WIDTH-1:0], the array's o_cost.
  - Outputs o_cost_last [WIDTH-1:0], o_cost_min [WIDTH-1:0], o_cost_valid (1 bit).
- In WRITE, i_cost is captured into o_cost_last.
- o_cost_min is preset to the most positive signed value on start. It is updated on each WRITE with the signed minimum of itself and i_cost.
- o_cost_valid pulses in the cycle after each capture. All three reset to 0.
- When undefined: none of these ports exist, and no cost logic is present.

Test Plan:
- Params NUM=4, NUM_LSTM=2, NUM_ITERATIONS=2, LSTM_LAT=3, BP_LAT=2, EPOCHS=2, NUM_SAMPLES=2, with start pulsed at cycle 0 → the following strobe timeline:
  - load_t cycles 1–2, addr 0,1.
  - load_in cycle 7; load_h/load_bp cycle 11; sel=1 from cycle 12.
  - load_in cycle 16; load_h/load_bp cycle 20.
  - wr cycle 23.
  - Second epoch label addr 2,3 at cycles 24–25; wr cycle 46; done cycle 47; busy falls at cycle 48.
- Second run after the first completes → label addresses start at 0 again (sample wrapped); the timeline is otherwise identical.
- i_abort asserted at cycle 15 of the first run → IDLE by cycle 16; no wr, no done; a new start runs a full, correct sequence.
- rst asserted asynchronously mid-COMP → all outputs 0 immediately, before the next edge; o_epoch=0.
- i_start held high for the whole run → exactly one run, then an immediate restart after DONE; no double-start while busy.
- With LSTM_BP_CTRL_COST_LOG_EN, feed i_cost 0x00400000 then 0x00200000 at the two WRITEs:
  - o_cost_last = 0x00200000, o_cost_min = 0x00200000, o_cost_valid pulses at cycles 24 and 47.
